// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_pkg                                             |
// | Description : Shared op encodings, FSM state type and default core   |
// |               latencies for the HI/LO multiply/divide sequencer.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package muldiv_pkg;

   // Operation encodings presented on the op port
   localparam logic [3:0] c_op_mult  = 4'b0101;
   localparam logic [3:0] c_op_multu = 4'b0110;
   localparam logic [3:0] c_op_div   = 4'b1011;
   localparam logic [3:0] c_op_divu  = 4'b0111;
   localparam logic [3:0] c_op_mthi  = 4'b1100;
   localparam logic [3:0] c_op_mtlo  = 4'b1101;

   // Default core latencies (first stable-input cycle to valid result)
   localparam int c_def_mul_lat = 5;
   localparam int c_def_div_lat = 28;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      DIV_BUSY = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_sign.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_sign                                            |
// | Description : Operand magnitude extraction and result sign fix-up.   |
// |               With i_chain set the two halves negate as one 64-bit   |
// |               value (product); cleared, each half negates on its     |
// |               own (quotient/remainder).                              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module muldiv_sign (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_signed,
   output logic [31:0] o_mag_a,
   output logic [31:0] o_mag_b,
   input  logic [63:0] i_res,
   input  logic        i_neg_hi,
   input  logic        i_neg_lo,
   input  logic        i_chain,
   output logic [63:0] o_res
);

   logic w_hi_carry;

   // 0x80000000 maps onto itself, read back as an unsigned magnitude
   assign o_mag_a = (i_signed & i_a[31]) ? (~i_a + 32'd1) : i_a;
   assign o_mag_b = (i_signed & i_b[31]) ? (~i_b + 32'd1) : i_b;

   // Carry from the low half into the high half only exists when chained
   assign w_hi_carry     = i_chain ? (i_res[31:0] == 32'd0) : 1'b1;
   assign o_res[31:0]    = i_neg_lo ? (~i_res[31:0] + 32'd1) : i_res[31:0];
   assign o_res[63:32]   = i_neg_hi ? (~i_res[63:32] + {31'd0, w_hi_carry})
                                    : i_res[63:32];

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_ctrl                                            |
// | Description : EX-stage sequencer for external multiplier/divider     |
// |               cores; stalls for the core latency, sign-corrects the  |
// |               result and owns architectural HI/LO.                   |
// |               Build macro MULDIV_DIVZERO_CHK_EN: DIV/DIVU by zero is |
// |               swallowed without launching the divider.               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT = c_def_mul_lat,
   parameter int DIV_LAT = c_def_div_lat
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        op_valid,
   input  logic [3:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_p,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   output logic        div_valid,
   input  logic [63:0] div_dout
);

   localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int c_cnt_w   = $clog2(c_max_lat + 1);

   state_t               r_state, w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
   logic                 r_neg_lo, r_neg_hi;
   logic [31:0]          r_mul_a, r_mul_b, r_div_a, r_div_b, r_hi, r_lo;
   logic                 w_is_mul, w_is_div, w_is_signed, w_div_go;
   logic                 w_accept, w_launch, w_done, w_sel_mul;
   logic [31:0]          w_mag_a, w_mag_b;
   logic [63:0]          w_res_raw, w_res;

   assign w_is_mul    = (op == c_op_mult) | (op == c_op_multu);
   assign w_is_div    = (op == c_op_div)  | (op == c_op_divu);
   assign w_is_signed = (op == c_op_mult) | (op == c_op_div);

`ifdef MULDIV_DIVZERO_CHK_EN
   assign w_div_go = w_is_div & (src_b != 32'd0);
`else
   assign w_div_go = w_is_div;
`endif

   assign w_accept  = (r_state == IDLE) & op_valid & ~flush & resetn;
   assign w_launch  = w_accept & (w_is_mul | w_div_go);
   assign w_done    = (r_state != IDLE) & ~flush & (r_cnt == c_cnt_w'(1));
   assign w_sel_mul = (r_state == MUL_BUSY);

   // Divider output is swapped so the remainder lands in the HI half
   assign w_res_raw = w_sel_mul ? mul_p : {div_dout[31:0], div_dout[63:32]};

   muldiv_sign u_sign (
      .i_a      (src_a),
      .i_b      (src_b),
      .i_signed (w_is_signed),
      .o_mag_a  (w_mag_a),
      .o_mag_b  (w_mag_b),
      .i_res    (w_res_raw),
      .i_neg_hi (w_sel_mul ? r_neg_lo : r_neg_hi),
      .i_neg_lo (r_neg_lo),
      .i_chain  (w_sel_mul),
      .o_res    (w_res)
   );

   // Next state and latency counter; flush beats the capture cycle
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_launch) begin
               if (w_is_mul) begin
                  w_state_nxt = MUL_BUSY;
                  w_cnt_nxt   = c_cnt_w'(MUL_LAT);
               end else begin
                  w_state_nxt = DIV_BUSY;
                  w_cnt_nxt   = c_cnt_w'(DIV_LAT);
               end
            end
         end
         MUL_BUSY, DIV_BUSY: begin
            w_cnt_nxt = r_cnt - c_cnt_w'(1);
            if (flush) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_cnt_w'(1)) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Core operand and sign-fixup capture on launch
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_mul_a  <= '0;
         r_mul_b  <= '0;
         r_div_a  <= '0;
         r_div_b  <= '0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
      end else if (w_launch) begin
         if (w_is_mul) begin
            r_mul_a <= w_mag_a;
            r_mul_b <= w_mag_b;
         end else begin
            r_div_a <= w_mag_a;
            r_div_b <= w_mag_b;
         end
         r_neg_lo <= w_is_signed & (src_a[31] ^ src_b[31]);
         r_neg_hi <= (op == c_op_div) & src_a[31];
      end
   end

   // Architectural HI/LO: direct moves in IDLE, core results on capture
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_accept & (op == c_op_mthi)) begin
         r_hi <= src_a;
      end else if (w_accept & (op == c_op_mtlo)) begin
         r_lo <= src_a;
      end else if (w_done) begin
         r_hi <= w_res[63:32];
         r_lo <= w_res[31:0];
      end
   end

   assign stall        = resetn & (w_launch | (r_state != IDLE));
   assign hi           = r_hi;
   assign lo           = r_lo;
   assign mul_a        = r_mul_a;
   assign mul_b        = r_mul_b;
   assign div_dividend = r_div_a;
   assign div_divisor  = r_div_b;
   assign div_valid    = (r_state == DIV_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_muldiv_ctrl                                         |
// | Description : Self-checking bench for muldiv_ctrl: directed vector   |
// |               table, hand-written corner sequences and random ops    |
// |               against an arithmetic reference model. Honours build   |
// |               macro MULDIV_DIVZERO_CHK_EN.                           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_muldiv_ctrl;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 28;

   localparam logic [3:0] MULT  = 4'b0101;
   localparam logic [3:0] MULTU = 4'b0110;
   localparam logic [3:0] DIV   = 4'b1011;
   localparam logic [3:0] DIVU  = 4'b0111;
   localparam logic [3:0] MTHI  = 4'b1100;
   localparam logic [3:0] MTLO  = 4'b1101;

   logic        clk = 1'b0;
   logic        resetn, op_valid, flush;
   logic [3:0]  op;
   logic [31:0] src_a, src_b;
   logic        stall, div_valid;
   logic [31:0] hi, lo, mul_a, mul_b, div_dividend, div_divisor;
   logic [63:0] mul_p, div_dout;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] m_hi, m_lo;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          flush_at;
      int          exp_stall;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
      .src_a(src_a), .src_b(src_b), .flush(flush), .stall(stall),
      .hi(hi), .lo(lo), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_valid(div_valid), .div_dout(div_dout)
   );

   // Idealised external cores (result ready whenever inputs are stable)
   always_comb begin
      mul_p = {32'd0, mul_a} * {32'd0, mul_b};
      if (div_divisor == 32'd0) div_dout = {32'hFFFF_FFFF, div_dividend};
      else div_dout = {div_dividend / div_divisor, div_dividend % div_divisor};
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Architectural result {HI,LO} from plain signed/unsigned arithmetic
   function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = $signed(a);
      sb = $signed(b);
      res = '0;
      case (o)
         MULT:  res = 64'(sa * sb);
         MULTU: res = {32'd0, a} * {32'd0, b};
         DIV: begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
         end
         DIVU:  res = {a % b, a / b};
         default: res = '0;
      endcase
      return res;
   endfunction

   // Present one op in the current cycle, count stall cycles until it drops
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int sc);
      op_valid = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0;
      sc = 0;
      for (int k = 0; k < 60; k++) begin
         if (k == flush_at) flush = 1'b1;
         #1;
         if (!stall) break;
         sc++;
         @(posedge clk); #1;
         op_valid = 1'b0; flush = 1'b0;
      end
      flush = 1'b0;
      if (sc == 0) begin
         @(posedge clk); #1;
         op_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      #1;
      while (stall && k < 100) begin
         @(posedge clk); #2;
         k++;
      end
      chk(name, 64'(stall), 64'd0);
   endtask

   task automatic add_vec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int fl, input int st, input logic [31:0] h, input logic [31:0] l);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.flush_at = fl; v.exp_stall = st;
      v.exp_hi = h; v.exp_lo = l;
      vq.push_back(v);
   endtask

   initial begin
      int sc;
      int cnt;
      logic [3:0] rops[6];
      rops = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO};

      add_vec(MULT,  32'hFFFF_FFFD, 32'd7,         -1,  6, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      add_vec(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1,  6, 32'hFFFF_FFFE, 32'h0000_0001);
      add_vec(DIV,   32'hFFFF_FFF9, 32'd2,         -1, 29, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      add_vec(DIVU,  32'd100,       32'd7,         -1, 29, 32'd2,         32'd14);
      add_vec(DIV,   32'd100,       32'd7,         10, 11, 32'd2,         32'd14);
      add_vec(MULT,  32'd3,         32'd5,         -1,  6, 32'd0,         32'd15);
      add_vec(MTHI,  32'h1234_5678, 32'd0,         -1,  0, 32'h1234_5678, 32'd15);
      add_vec(MTLO,  32'h9ABC_DEF0, 32'd0,         -1,  0, 32'h1234_5678, 32'h9ABC_DEF0);
      add_vec(4'b0000, 32'd1,       32'd1,         -1,  0, 32'h1234_5678, 32'h9ABC_DEF0);
      add_vec(MULT,  32'h8000_0000, 32'hFFFF_FFFF, -1,  6, 32'd0,         32'h8000_0000);
      add_vec(DIV,   32'd7,         32'hFFFF_FFFE, -1, 29, 32'd1,         32'hFFFF_FFFD);
      add_vec(MULT,  32'd2,         32'd2,          5,  6, 32'd1,         32'hFFFF_FFFD);
      add_vec(DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 29, 32'd0,         32'h8000_0000);
`ifdef MULDIV_DIVZERO_CHK_EN
      add_vec(DIV,   32'd5,         32'd0,         -1,  0, 32'd0,         32'h8000_0000);
`else
      add_vec(DIV,   32'd5,         32'd0,         -1, 29, 32'd5,         32'hFFFF_FFFF);
`endif
      add_vec(MULTU, 32'd0,         32'd12345,     -1,  6, 32'd0,         32'd0);
      add_vec(DIVU,  32'hFFFF_FFFF, 32'd10,        -1, 29, 32'd5,         32'h1999_9999);

      // Reset state, including stall held low while resetn is low
      resetn = 1'b0; op_valid = 1'b1; op = MULT; src_a = 32'd3; src_b = 32'd4; flush = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_stall", 64'(stall), 64'd0);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_mul_ops", {mul_a, mul_b}, 64'd0);
      chk("reset_div_ops", {div_dividend, div_divisor}, 64'd0);
      chk("reset_div_valid", 64'(div_valid), 64'd0);
      resetn = 1'b1; op_valid = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;

      // Flush blocks acceptance in IDLE
      @(posedge clk); #1;
      op_valid = 1'b1; op = MULT; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
      #1;
      chk("flush_block_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      op_valid = 1'b0; flush = 1'b0;
      #1;
      chk("flush_block_idle", 64'(stall), 64'd0);
      chk("flush_block_mul_a", 64'(mul_a), 64'd0);

      // Directed vector table
      foreach (vq[i]) begin
         issue(vq[i].op, vq[i].a, vq[i].b, vq[i].flush_at, sc);
         chk($sformatf("vec%0d_stall", i), 64'(sc), 64'(vq[i].exp_stall));
         chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vq[i].exp_hi));
         chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vq[i].exp_lo));
         m_hi = vq[i].exp_hi;
         m_lo = vq[i].exp_lo;
      end

      // Randomised ops against the arithmetic model
      for (int n = 0; n < 40; n++) begin
         logic [3:0]  o;
         logic [31:0] a, b;
         logic [63:0] r;
         int fl, lat, est;
         o = rops[$urandom_range(0, 5)];
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(16, 31);
         if ($urandom_range(0, 3) == 0) b = -b;
         if ((o == DIV || o == DIVU) && b == 32'd0) b = 32'd3;
         lat = (o == MULT || o == MULTU) ? MUL_LAT : DIV_LAT;
         fl = -1;
         if (o != MTHI && o != MTLO && $urandom_range(0, 3) == 0)
            fl = $urandom_range(1, lat);
         issue(o, a, b, fl, sc);
         if (o == MTHI) begin
            est = 0; m_hi = a;
         end else if (o == MTLO) begin
            est = 0; m_lo = a;
         end else if (fl >= 0) begin
            est = fl + 1;
         end else begin
            est = lat + 1;
            r = ref_res(o, a, b);
            m_hi = r[63:32];
            m_lo = r[31:0];
         end
         chk($sformatf("rnd%0d_stall op=%b", n, o), 64'(sc), 64'(est));
         chk($sformatf("rnd%0d_hilo op=%b a=%h b=%h", n, o, a, b), {hi, lo}, {m_hi, m_lo});
      end

      // Divider interface timing: inputs and div_valid from T+1 to T+DIV_LAT
      op_valid = 1'b1; op = DIV; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
      #1;
      chk("div_accept_stall", 64'(stall), 64'd1);
      @(posedge clk); #1;
      op_valid = 1'b0;
      #1;
      chk("div_operands", {div_dividend, div_divisor}, {32'd7, 32'd2});
      cnt = 0;
      while (div_valid && cnt < 100) begin
         cnt++;
         @(posedge clk); #2;
      end
      chk("div_valid_len", 64'(cnt), 64'(DIV_LAT));
      chk("div_done_stall", 64'(stall), 64'd0);
      chk("div_done_lo", 64'(lo), 64'hFFFF_FFFD);

      // Multiplier inputs are registered magnitudes
      op_valid = 1'b1; op = MULT; src_a = 32'hFFFF_FFFD; src_b = 32'd7;
      @(posedge clk); #1;
      op_valid = 1'b0;
      #1;
      chk("mult_mag", {mul_a, mul_b}, {32'd3, 32'd7});
      wait_idle("mult_idle");
      op_valid = 1'b1; op = MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      op_valid = 1'b0;
      #1;
      chk("multu_raw", {mul_a, mul_b}, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_idle("multu_idle");
      chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      // Reset in the middle of an operation
      op_valid = 1'b1; op = MULT; src_a = 32'd3; src_b = 32'd5;
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      chk("midreset_stall_low", 64'(stall), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      #1;
      chk("midreset_hilo", {hi, lo}, 64'd0);
      chk("midreset_mul_a", 64'(mul_a), 64'd0);
      chk("midreset_idle", 64'(stall), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
